// File: rtl/bus_mem_responder.sv
// rtl/bus_mem_responder.sv - clocked SM83 external-bus memory responder with transaction log FIFO
//
// Serves reads from a preloadable byte array after RD_LAT cycles, commits writes, and logs every
// completed or aborted bus cycle into a FIFO for later draining.
//
// Ports:
//   CLK        in     responder clock
//   RESET_N    in     asynchronous reset, active low (array contents survive reset)
//   MREQ/RD/WR in     core bus strobes, sampled on CLK rise
//   A          in 16  core address bus
//   D          inout 8 core data bus, driven only while a read is in its drive phase
//   LOAD_EN    in     preload strobe, honoured only while idle
//   LOAD_ADDR  in AW  preload index
//   LOAD_DATA  in 8   preload byte
//   LOG_VALID  out    log FIFO non-empty
//   LOG_READY  in     log pop request
//   LOG_DATA   out 26 head entry {abort, wr, addr[15:0], data[7:0]}
//   LOG_OVF    out    sticky: a log entry was dropped
//   BUS_ERR    out    sticky: RD and WR seen together with MREQ
//   BUSY       out    a bus cycle is in progress
module bus_mem_responder #(
    parameter int          AW        = 13,
    parameter logic [15:0] BASE      = 16'h0000,
    parameter int          RD_LAT    = 1,
    parameter int          LOG_DEPTH = 8
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          MREQ,
    input  logic          RD,
    input  logic          WR,
    input  logic [15:0]   A,
    inout  wire  [7:0]    D,
    input  logic          LOAD_EN,
    input  logic [AW-1:0] LOAD_ADDR,
    input  logic [7:0]    LOAD_DATA,
    output logic          LOG_VALID,
    input  logic          LOG_READY,
    output logic [25:0]   LOG_DATA,
    output logic          LOG_OVF,
    output logic          BUS_ERR,
    output logic          BUSY
);

    localparam int          PW       = $clog2(LOG_DEPTH) + 1;
    localparam logic [16:0] WIN_SIZE = 17'(1) << AW;
    // AW=16 makes the size wrap to zero, which correctly yields an all-zero mask.
    localparam logic [15:0] WIN_MASK = ~(WIN_SIZE[15:0] - 16'd1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_DRIVE,
        S_WR_CAPT
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    dout_q, dout_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          drive_en_q, drive_en_d;
    logic          bus_err_q, bus_err_d;
    logic          log_ovf_q;
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;

    logic [7:0]    mem [2**AW];
    logic [25:0]   fifo_q [LOG_DEPTH];

    logic          hit, req;
    logic          push, push_ok, pop, fifo_full, fifo_empty;
    logic [25:0]   push_data;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;

    assign hit = (A & WIN_MASK) == BASE;
    assign req = MREQ & hit;

    assign D = drive_en_q ? dout_q : 8'bz;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        dout_d     = dout_q;
        wdata_d    = wdata_q;
        drive_en_d = drive_en_q;
        bus_err_d  = bus_err_q;
        push       = 1'b0;
        push_data  = '0;
        mem_we     = 1'b0;
        mem_waddr  = LOAD_ADDR;
        mem_wdata  = LOAD_DATA;
        unique case (state_q)
            S_IDLE: begin
                if (req && RD && WR) begin
                    bus_err_d = 1'b1;
                end else if (req && RD) begin
                    state_d = S_RD_WAIT;
                    cnt_d   = 4'(RD_LAT - 1);
                    addr_d  = A;
                end else if (req && WR) begin
                    state_d = S_WR_CAPT;
                    addr_d  = A;
                    wdata_d = D;
                end else if (LOAD_EN) begin
                    mem_we = 1'b1;
                end
            end
            S_RD_WAIT: begin
                if (!(MREQ && RD)) begin
                    push      = 1'b1;
                    push_data = {2'b10, addr_q, 8'h00};
                    state_d   = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d    = S_RD_DRIVE;
                    dout_d     = mem[addr_q[AW-1:0]];
                    drive_en_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RD_DRIVE: begin
                if (!(MREQ && RD)) begin
                    drive_en_d = 1'b0;
                    push       = 1'b1;
                    push_data  = {2'b00, addr_q, dout_q};
                    state_d    = S_IDLE;
                end
            end
            S_WR_CAPT: begin
                if (MREQ && WR) begin
                    wdata_d = D;
                end else begin
                    // Commit in the same edge that returns to idle, so a read
                    // entered on the next edge already sees the new byte.
                    mem_we    = 1'b1;
                    mem_waddr = addr_q[AW-1:0];
                    mem_wdata = wdata_q;
                    push      = 1'b1;
                    push_data = {2'b01, addr_q, wdata_q};
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    assign pop        = !fifo_empty && LOG_READY;
    // A pop in the same cycle frees the head slot, so a push into a full FIFO is still accepted.
    assign push_ok    = push && (!fifo_full || pop);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            dout_q     <= '0;
            wdata_q    <= '0;
            drive_en_q <= 1'b0;
            bus_err_q  <= 1'b0;
            log_ovf_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            wdata_q    <= wdata_d;
            drive_en_q <= drive_en_d;
            bus_err_q  <= bus_err_d;
            if (push && !push_ok) log_ovf_q <= 1'b1;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Storage arrays carry no reset: the byte array must survive RESET_N.
    always_ff @(posedge CLK) begin
        if (mem_we)  mem[mem_waddr] <= mem_wdata;
        if (push_ok) fifo_q[wr_ptr_q[PW-2:0]] <= push_data;
    end

    assign LOG_VALID = !fifo_empty;
    assign LOG_DATA  = fifo_q[rd_ptr_q[PW-2:0]];
    assign LOG_OVF   = log_ovf_q;
    assign BUS_ERR   = bus_err_q;
    assign BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_bus_mem_responder.sv
// tb/tb_bus_mem_responder.sv - self-checking bench for bus_mem_responder
module tb_bus_mem_responder;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 8;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        MREQ = 1'b0, RD = 1'b0, WR = 1'b0;
    logic [15:0] A = '0;
    tri1  [7:0]  D;
    logic        tb_d_oe = 1'b0;
    logic [7:0]  tb_d = '0;
    logic        LOAD_EN = 1'b0;
    logic [12:0] LOAD_ADDR = '0;
    logic [7:0]  LOAD_DATA = '0;
    logic        LOG_VALID;
    logic        LOG_READY = 1'b0;
    logic [25:0] LOG_DATA;
    logic        LOG_OVF, BUS_ERR, BUSY;

    assign D = tb_d_oe ? tb_d : 8'bz;

    bus_mem_responder #(.AW(13), .BASE(16'h0000), .RD_LAT(RD_LAT), .LOG_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .MREQ(MREQ), .RD(RD), .WR(WR), .A(A), .D(D),
        .LOAD_EN(LOAD_EN), .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA),
        .LOG_VALID(LOG_VALID), .LOG_READY(LOG_READY), .LOG_DATA(LOG_DATA),
        .LOG_OVF(LOG_OVF), .BUS_ERR(BUS_ERR), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mem_model [0:8191];
    logic [25:0] exp_q [$];
    logic        exp_ovf = 1'b0;
    logic        exp_err = 1'b0;
    logic [12:0] pool [16];

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_win(input logic [15:0] a);
        return (a & ~16'h1FFF) == 16'h0000;
    endfunction

    // Reference log: optional pop of the head, then push if room remains.
    function automatic void log_event(input bit has_push, input logic [25:0] e, input bit popped);
        if (popped && exp_q.size() > 0) void'(exp_q.pop_front());
        if (has_push) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(e);
            else exp_ovf = 1'b1;
        end
    endfunction

    task automatic preload(input logic [12:0] a, input logic [7:0] d);
        LOAD_EN = 1'b1; LOAD_ADDR = a; LOAD_DATA = d;
        tick();
        LOAD_EN = 1'b0;
        mem_model[a] = d;
    endtask

    task automatic do_read(input logic [15:0] a, input int hold, input bit pop_at_end, input bit move_addr);
        bit         hit;
        logic [7:0] exp_d;
        hit   = in_win(a);
        exp_d = hit ? mem_model[a[12:0]] : 8'hFF;
        MREQ = 1'b1; RD = 1'b1; A = a;
        for (int k = 0; k < RD_LAT; k++) begin
            tick();
            if (move_addr && k == 0) A = a ^ 16'h0001;
        end
        chk("rd_before_latency", D, 8'hFF);
        tick();
        chk("rd_data", D, exp_d);
        chk("rd_busy", BUSY, hit);
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("rd_hold", D, exp_d);
        end
        MREQ = 1'b0; RD = 1'b0; LOG_READY = pop_at_end;
        tick();
        LOG_READY = 1'b0;
        chk("rd_released", D, 8'hFF);
        chk("rd_idle", BUSY, 1'b0);
        log_event(hit, {2'b00, a, exp_d}, pop_at_end);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d1, input logic [7:0] d2, input int extra);
        bit         hit;
        logic [7:0] fin;
        hit = in_win(a);
        fin = (extra > 0) ? d2 : d1;
        MREQ = 1'b1; WR = 1'b1; A = a; tb_d_oe = 1'b1; tb_d = d1;
        tick();
        for (int k = 0; k < extra; k++) begin
            tb_d = d2;
            tick();
        end
        chk("wr_busy", BUSY, hit);
        MREQ = 1'b0; WR = 1'b0; tb_d_oe = 1'b0;
        tick();
        chk("wr_idle", BUSY, 1'b0);
        if (hit) mem_model[a[12:0]] = fin;
        log_event(hit, {2'b01, a, fin}, 1'b0);
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            chk("log_valid", LOG_VALID, 1'b1);
            chk("log_data", LOG_DATA, exp_q[0]);
            LOG_READY = 1'b1;
            tick();
            LOG_READY = 1'b0;
            void'(exp_q.pop_front());
        end
        chk("log_empty", LOG_VALID, 1'b0);
        chk("log_ovf", LOG_OVF, exp_ovf);
        chk("bus_err", BUS_ERR, exp_err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_valid", LOG_VALID, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_ovf", LOG_OVF, 1'b0);
        chk("rst_err", BUS_ERR, 1'b0);
        chk("rst_d", D, 8'hFF);
        RESET_N = 1'b1;
        tick();

        preload(13'h0100, 8'h3E);
        for (int i = 0; i < 16; i++) begin
            pool[i] = 13'($urandom_range(0, 8191));
            preload(pool[i], 8'($urandom_range(0, 254)));
        end
        preload(13'h0100, 8'h3E);

        // Basic read with latency and release
        do_read(16'h0100, 1, 1'b0, 1'b0);
        drain();

        // Write, then immediate read of the same byte
        do_write(16'h0105, 8'hA5, 8'h00, 0);
        do_read(16'h0105, 0, 1'b0, 1'b0);
        drain();

        // Write re-latch (last value wins) and address change ignored during a read
        do_write(16'h0106, 8'h12, 8'h34, 2);
        do_read(16'h0106, 2, 1'b0, 1'b1);
        drain();

        // LOAD_EN outside idle is ignored
        MREQ = 1'b1; RD = 1'b1; A = 16'h0100;
        tick();
        LOAD_EN = 1'b1; LOAD_ADDR = 13'h0100; LOAD_DATA = 8'h11;
        tick();
        LOAD_EN = 1'b0;
        tick();
        chk("load_ignored", D, 8'h3E);
        MREQ = 1'b0; RD = 1'b0;
        tick();
        log_event(1'b1, {2'b00, 16'h0100, 8'h3E}, 1'b0);
        drain();

        // Abort in the wait phase: never driven, abort entry logged
        MREQ = 1'b1; RD = 1'b1; A = 16'h0222;
        tick();
        chk("abort_wait_d", D, 8'hFF);
        chk("abort_wait_busy", BUSY, 1'b1);
        RD = 1'b0;
        tick();
        MREQ = 1'b0;
        chk("abort_d", D, 8'hFF);
        chk("abort_busy", BUSY, 1'b0);
        log_event(1'b1, {2'b10, 16'h0222, 8'h00}, 1'b0);
        drain();

        // Overflow: nine reads with no pops, then full with same-cycle push/pop
        for (int i = 0; i < 9; i++) do_read({3'b000, pool[i]}, 0, 1'b0, 1'b0);
        chk("ovf_set", LOG_OVF, 1'b1);
        chk("ovf_head_before", LOG_DATA, exp_q[0]);
        tick();
        chk("ovf_head_stable", LOG_DATA, exp_q[0]);
        do_read({3'b000, pool[9]}, 0, 1'b1, 1'b0);
        chk("ovf_count", exp_q.size(), DEPTH);
        drain();
        LOG_READY = 1'b1;
        tick();
        LOG_READY = 1'b0;
        chk("pop_empty", LOG_VALID, 1'b0);

        // Bus error and window miss
        MREQ = 1'b1; RD = 1'b1; WR = 1'b1; A = 16'h0010;
        tick();
        exp_err = 1'b1;
        chk("err_set", BUS_ERR, 1'b1);
        chk("err_busy", BUSY, 1'b0);
        MREQ = 1'b0; RD = 1'b0; WR = 1'b0;
        tick();
        chk("err_nolog", LOG_VALID, 1'b0);
        do_read(16'h4000, 0, 1'b0, 1'b0);
        chk("miss_nolog", LOG_VALID, 1'b0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            int op;
            op = $urandom_range(0, 3);
            case (op)
                0, 1: do_read({3'b000, pool[$urandom_range(0, 15)]}, $urandom_range(0, 2),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                2: do_write({3'b000, pool[$urandom_range(0, 15)]}, 8'($urandom_range(0, 254)),
                            8'($urandom_range(0, 254)), $urandom_range(0, 2));
                default: begin
                    if ($urandom_range(0, 1) == 1)
                        do_read({3'($urandom_range(1, 7)), 13'($urandom_range(0, 8191))}, 0, 1'b0, 1'b0);
                    else
                        do_write({3'($urandom_range(1, 7)), 13'($urandom_range(0, 8191))},
                                 8'h5A, 8'h00, 0);
                end
            endcase
            if (exp_q.size() >= 6) drain();
        end
        drain();

        // Reset in the middle of a drive phase
        MREQ = 1'b1; RD = 1'b1; A = 16'h0100;
        repeat (RD_LAT + 1) tick();
        chk("pre_reset_d", D, 8'h3E);
        #2 RESET_N = 1'b0;
        #1;
        chk("async_rst_d", D, 8'hFF);
        chk("async_rst_valid", LOG_VALID, 1'b0);
        chk("async_rst_busy", BUSY, 1'b0);
        chk("async_rst_err", BUS_ERR, 1'b0);
        chk("async_rst_ovf", LOG_OVF, 1'b0);
        MREQ = 1'b0; RD = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_err = 1'b0;
        tick();
        do_read(16'h0100, 0, 1'b0, 1'b0);
        do_read({3'b000, pool[3]}, 0, 1'b0, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
